// File: rtl/out_vc_credit_tracker.sv
// ============================================================================
// Module  : out_vc_credit_tracker
// Purpose : Per-output-port downstream credit counts and output-VC ownership.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module out_vc_credit_tracker #(
  parameter int NUM_VC = 4,
  parameter int VCW    = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [VCW-1:0]    alloc_vc,
  input  logic              send_valid,
  input  logic [VCW-1:0]    send_vc,
  input  logic              send_tail,
  input  logic              cred_valid,
  input  logic [VCW-1:0]    cred_vc,
  input  logic [VCW-1:0]    query_vc,
  output logic [2:0]        C,
  output logic [NUM_VC-1:0] credit_avail,
  output logic [NUM_VC-1:0] vc_busy,
  output logic [NUM_VC-1:0] vc_idle,
  output logic              err
);

  localparam logic [2:0]   C_DEPTH  = 3'(DEPTH);
  localparam logic [VCW:0] C_NUM_VC = (VCW+1)'(NUM_VC);

  logic [2:0]        r_count [NUM_VC];
  logic [NUM_VC-1:0] r_busy;
  logic              r_err;

  logic [2:0]        w_cnt_nxt [NUM_VC];
  logic [NUM_VC-1:0] w_busy_nxt;
  logic [NUM_VC-1:0] w_alloc_hit;
  logic [NUM_VC-1:0] w_send_hit;
  logic [NUM_VC-1:0] w_cred_hit;
  logic [NUM_VC-1:0] w_uflow;
  logic [NUM_VC-1:0] w_oflow;
  logic              w_oor;
  logic              w_bad_alloc;
  logic              w_bad_send;
  logic              w_err_nxt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      assign w_alloc_hit[gi]  = alloc_valid && (alloc_vc == VCW'(gi));
      assign w_send_hit[gi]   = send_valid  && (send_vc  == VCW'(gi));
      assign w_cred_hit[gi]   = cred_valid  && (cred_vc  == VCW'(gi));
      assign credit_avail[gi] = (r_count[gi] != 3'd0);
      assign vc_idle[gi]      = !r_busy[gi] && (r_count[gi] == C_DEPTH);

      // A simultaneous send and credit on one VC cancel, even at 0 or DEPTH.
      always_comb begin
        w_cnt_nxt[gi] = r_count[gi];
        w_uflow[gi]   = 1'b0;
        w_oflow[gi]   = 1'b0;
        case ({w_cred_hit[gi], w_send_hit[gi]})
          2'b10: begin
            if (r_count[gi] == C_DEPTH) w_oflow[gi] = 1'b1;
            else                        w_cnt_nxt[gi] = r_count[gi] + 3'd1;
          end
          2'b01: begin
            if (r_count[gi] == 3'd0) w_uflow[gi] = 1'b1;
            else                     w_cnt_nxt[gi] = r_count[gi] - 3'd1;
          end
          default: w_cnt_nxt[gi] = r_count[gi];
        endcase
      end

      // A new allocation wins over a tail leaving on the same VC.
      assign w_busy_nxt[gi] = w_alloc_hit[gi] ||
                              (r_busy[gi] && !(w_send_hit[gi] && send_tail));
    end
  endgenerate

  assign w_oor = (alloc_valid && ({1'b0, alloc_vc} >= C_NUM_VC)) ||
                 (send_valid  && ({1'b0, send_vc}  >= C_NUM_VC)) ||
                 (cred_valid  && ({1'b0, cred_vc}  >= C_NUM_VC));

  assign w_bad_alloc = |(w_alloc_hit & ~vc_idle);
  assign w_bad_send  = |(w_send_hit & ~r_busy);
  assign w_err_nxt   = r_err | w_oor | w_bad_alloc | w_bad_send |
                       (|w_uflow) | (|w_oflow);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_VC; i++) r_count[i] <= C_DEPTH;
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) r_count[i] <= w_cnt_nxt[i];
      r_busy <= w_busy_nxt;
      r_err  <= w_err_nxt;
    end
  end

  always_comb begin
    C = 3'd0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (query_vc == VCW'(i)) C = r_count[i];
    end
  end

  assign vc_busy = r_busy;
  assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_out_vc_credit_tracker.sv
// ============================================================================
// Module  : tb_out_vc_credit_tracker
// Purpose : Directed scoreboard bench for out_vc_credit_tracker.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_out_vc_credit_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_valid = 1'b0;
  logic [1:0] alloc_vc = '0;
  logic       send_valid = 1'b0;
  logic [1:0] send_vc = '0;
  logic       send_tail = 1'b0;
  logic       cred_valid = 1'b0;
  logic [1:0] cred_vc = '0;
  logic [1:0] query_vc = '0;
  logic [2:0] C;
  logic [3:0] credit_avail;
  logic [3:0] vc_busy;
  logic [3:0] vc_idle;
  logic       err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [2:0] c;
    logic [3:0] avail;
    logic [3:0] busy;
    logic [3:0] idle;
    logic       err;
  } exp_t;

  exp_t sb[$];

  out_vc_credit_tracker #(.NUM_VC(4), .VCW(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_vc(alloc_vc),
    .send_valid(send_valid), .send_vc(send_vc), .send_tail(send_tail),
    .cred_valid(cred_valid), .cred_vc(cred_vc),
    .query_vc(query_vc),
    .C(C), .credit_avail(credit_avail), .vc_busy(vc_busy),
    .vc_idle(vc_idle), .err(err)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [2:0] c, input logic [3:0] av,
                          input logic [3:0] bz, input logic [3:0] id, input logic e);
    exp_t x;
    x.tag = tag; x.c = c; x.avail = av; x.busy = bz; x.idle = id; x.err = e;
    sb.push_back(x);
  endtask

  task automatic check_pop();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    x = sb.pop_front();
    checks++;
    assert (C === x.c) else begin
      errors++; $error("FAIL %s.C observed=%0d expected=%0d", x.tag, C, x.c);
    end
    checks++;
    assert (credit_avail === x.avail) else begin
      errors++; $error("FAIL %s.credit_avail observed=%b expected=%b", x.tag, credit_avail, x.avail);
    end
    checks++;
    assert (vc_busy === x.busy) else begin
      errors++; $error("FAIL %s.vc_busy observed=%b expected=%b", x.tag, vc_busy, x.busy);
    end
    checks++;
    assert (vc_idle === x.idle) else begin
      errors++; $error("FAIL %s.vc_idle observed=%b expected=%b", x.tag, vc_idle, x.idle);
    end
    checks++;
    assert (err === x.err) else begin
      errors++; $error("FAIL %s.err observed=%b expected=%b", x.tag, err, x.err);
    end
  endtask

  // One clock step: drive events, record the post-edge expectation, compare.
  task automatic step(input string tag,
                      input logic av, input logic [1:0] avc,
                      input logic sv, input logic [1:0] svc, input logic st,
                      input logic cv, input logic [1:0] cvc,
                      input logic [1:0] q,
                      input logic [2:0] ec, input logic [3:0] eav, input logic [3:0] ebz,
                      input logic [3:0] eid, input logic ee);
    alloc_valid = av; alloc_vc = avc;
    send_valid = sv; send_vc = svc; send_tail = st;
    cred_valid = cv; cred_vc = cvc;
    query_vc = q;
    push_exp(tag, ec, eav, ebz, eid, ee);
    @(posedge clk);
    #1;
    alloc_valid = 1'b0; send_valid = 1'b0; send_tail = 1'b0; cred_valid = 1'b0;
    check_pop();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_exp(tag, 3'd4, 4'hF, 4'h0, 4'hF, 1'b0);
    check_pop();
    rst = 1'b1;
  endtask

  initial begin
    do_reset("reset");

    // Basic packet on VC2
    step("pk_alloc", 1,2, 0,0,0, 0,0, 2, 3'd4, 4'hF, 4'b0100, 4'b1011, 0);
    step("pk_s1",    0,0, 1,2,0, 0,0, 2, 3'd3, 4'hF, 4'b0100, 4'b1011, 0);
    step("pk_s2",    0,0, 1,2,0, 0,0, 2, 3'd2, 4'hF, 4'b0100, 4'b1011, 0);
    step("pk_tail",  0,0, 1,2,1, 0,0, 2, 3'd1, 4'hF, 4'b0000, 4'b1011, 0);
    step("pk_c1",    0,0, 0,0,0, 1,2, 2, 3'd2, 4'hF, 4'b0000, 4'b1011, 0);
    step("pk_c2",    0,0, 0,0,0, 1,2, 2, 3'd3, 4'hF, 4'b0000, 4'b1011, 0);
    step("pk_c3",    0,0, 0,0,0, 1,2, 2, 3'd4, 4'hF, 4'b0000, 4'b1111, 0);

    // Query change visible without a clock edge
    query_vc = 2'd1;
    #1;
    push_exp("query_comb", 3'd4, 4'hF, 4'b0000, 4'b1111, 0);
    check_pop();

    // Starvation on VC1
    step("st_alloc", 1,1, 0,0,0, 0,0, 1, 3'd4, 4'hF,    4'b0010, 4'b1101, 0);
    step("st_s1",    0,0, 1,1,0, 0,0, 1, 3'd3, 4'hF,    4'b0010, 4'b1101, 0);
    step("st_s2",    0,0, 1,1,0, 0,0, 1, 3'd2, 4'hF,    4'b0010, 4'b1101, 0);
    step("st_s3",    0,0, 1,1,0, 0,0, 1, 3'd1, 4'hF,    4'b0010, 4'b1101, 0);
    step("st_s4",    0,0, 1,1,0, 0,0, 1, 3'd0, 4'b1101, 4'b0010, 4'b1101, 0);
    step("st_under", 0,0, 1,1,0, 0,0, 1, 3'd0, 4'b1101, 4'b0010, 4'b1101, 1);

    do_reset("reset2");

    // Simultaneous send and credit on VC3 at 0 and at DEPTH
    step("sim_alloc", 1,3, 0,0,0, 0,0, 3, 3'd4, 4'hF,    4'b1000, 4'b0111, 0);
    for (int i = 0; i < 4; i++)
      step("sim_drain", 0,0, 1,3,0, 0,0, 3, 3'(3 - i), (i == 3) ? 4'b0111 : 4'hF,
           4'b1000, 4'b0111, 0);
    step("sim_at0",   0,0, 1,3,0, 1,3, 3, 3'd0, 4'b0111, 4'b1000, 4'b0111, 0);
    for (int i = 0; i < 4; i++)
      step("sim_fill", 0,0, 0,0,0, 1,3, 3, 3'(i + 1), 4'hF, 4'b1000, 4'b0111, 0);
    step("sim_atD",   0,0, 1,3,0, 1,3, 3, 3'd4, 4'hF,    4'b1000, 4'b0111, 0);

    do_reset("reset3");

    // Overflow on VC0
    step("ovf",       0,0, 0,0,0, 1,0, 0, 3'd4, 4'hF, 4'b0000, 4'b1111, 1);

    do_reset("reset4");

    // Allocation of an already-busy VC
    step("ba_a1",     1,1, 0,0,0, 0,0, 1, 3'd4, 4'hF, 4'b0010, 4'b1101, 0);
    step("ba_a2",     1,1, 0,0,0, 0,0, 1, 3'd4, 4'hF, 4'b0010, 4'b1101, 1);

    do_reset("reset5");

    // Send on an unallocated VC: error, credit still consumed
    step("nobusy",    0,0, 1,0,0, 0,0, 0, 3'd3, 4'hF, 4'b0000, 4'b1110, 1);

    do_reset("reset6");

    // Alloc and tail on the same VC in one cycle: new packet keeps it busy
    step("at_alloc",  1,0, 0,0,0, 0,0, 0, 3'd4, 4'hF, 4'b0001, 4'b1110, 0);
    step("at_both",   1,0, 1,0,1, 0,0, 0, 3'd3, 4'hF, 4'b0001, 4'b1110, 1);

    do_reset("reset7");

    // Asynchronous reset mid-packet on VC2
    step("ar_alloc",  1,2, 0,0,0, 0,0, 2, 3'd4, 4'hF, 4'b0100, 4'b1011, 0);
    step("ar_s1",     0,0, 1,2,0, 0,0, 2, 3'd3, 4'hF, 4'b0100, 4'b1011, 0);
    step("ar_s2",     0,0, 1,2,0, 0,0, 2, 3'd2, 4'hF, 4'b0100, 4'b1011, 0);
    step("ar_s3",     0,0, 1,2,0, 0,0, 2, 3'd1, 4'hF, 4'b0100, 4'b1011, 0);
    #2;
    rst = 1'b0;
    #1;
    push_exp("async_rst", 3'd4, 4'hF, 4'b0000, 4'hF, 0);
    check_pop();
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/out_vc_credit_tracker.md
# out_vc_credit_tracker

Per-output-port tracker of downstream buffer credits and output-VC ownership. It sits directly downstream of the per-input VC state block and supplies that block's 3-bit credit count `C` for the output VC it holds (`R`/`O`). It also provides the busy/idle view of output VCs that VC allocation uses. One instance exists per router output port.

## Interface
- `NUM_VC`, 4: output VCs on this port; range 2..8.
- `VCW`, 2: VC index width, equal to clog2(`NUM_VC`).
- `DEPTH`, 4: downstream buffer slots per VC, and the reset/full credit value; range 1..7 so it fits 3 bits.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `alloc_valid`  in  1  an output VC is granted this cycle.
- `alloc_vc`  in  VCW  VC being granted.
- `send_valid`  in  1  a flit leaves on this port this cycle.
- `send_vc`  in  VCW  VC of the departing flit.
- `send_tail`  in  1  the departing flit is a tail flit.
- `cred_valid`  in  1  a credit is returned from downstream this cycle.
- `cred_vc`  in  VCW  VC the credit belongs to.
- `query_vc`  in  VCW  VC whose count drives `C`.
- `C`  out  3  credit count of `query_vc`.
- `credit_avail`  out  NUM_VC  bit i set when count[i] != 0.
- `vc_busy`  out  NUM_VC  bit i set when VC i is allocated to a packet.
- `vc_idle`  out  NUM_VC  bit i set when !busy[i] and count[i] == DEPTH; only these VCs may be allocated.
- `err`  out  1  sticky protocol-violation flag.

## Operation
- State per VC: 3-bit `count[i]` and 1-bit `busy[i]`. There is also one sticky `err` bit.
- Credit update, per VC i, each cycle:
  - Decrement when `send_valid && send_vc==i`.
  - Increment when `cred_valid && cred_vc==i`.
  - Both on the same VC: count is unchanged (net zero), even at 0 or DEPTH.
- Underflow: a send to a VC with count 0 and no same-cycle credit leaves count at 0 and sets `err`.
- Overflow: a credit to a VC with count DEPTH and no same-cycle send leaves count at DEPTH and sets `err`.
- Busy tracking:
  - `alloc_valid` sets `busy[alloc_vc]`.
  - `send_valid && send_tail` clears `busy[send_vc]`.
  - Alloc and tail-send on the same VC in the same cycle: busy ends at 1 (the new packet owns the VC).
- Allocation of a VC whose `vc_idle` is 0 is still recorded (busy is set) and also sets `err`.
- A send to a VC with busy=0 sets `err`; the credit effect still applies.
- `err` is cleared only by reset.
- Reset values: every count = DEPTH, every busy = 0, err = 0. Therefore `C` = DEPTH, `credit_avail` = all ones, `vc_busy` = 0, `vc_idle` = all ones.
- Reset asserted mid-packet discards all state immediately, independent of `clk`.

## Timing
- All state is registered.
- Inputs sampled at edge N take effect in state and outputs after edge N (one-cycle latency).
- `C` is a combinational read of registered `count[query_vc]`: a change of `query_vc` is visible in the same cycle, while a count update is visible the cycle after the event.
- `credit_avail`, `vc_busy` and `vc_idle` are combinational decodes of registered state; they have no input-to-output combinational path.
- Up to one send, one credit and one alloc are handled per cycle, to any VCs, independently.
- Out-of-range VC indices (≥ NUM_VC) have no effect on state and set `err`.

## Test plan
- Reset check: with defaults, drive `rst`=0, then release → `C`=4, `credit_avail`=4'b1111, `vc_busy`=0, `vc_idle`=4'b1111, `err`=0.
- Basic packet: alloc VC2; send 3 flits on VC2 with the last flagged tail; `query_vc`=2.
  - `C` steps 4→3→2→1, one cycle after each send.
  - `vc_busy[2]` rises after the alloc and falls after the tail.
  - `vc_idle[2]` stays 0 until 3 credits on VC2 return `C` to 4.
- Starvation: 4 sends on VC1 → `C`=0 and `credit_avail[1]`=0. A 5th send → count stays 0 and `err`=1 next cycle.
- Simultaneous events: at count 0, send and credit on VC3 in the same cycle → count stays 0 and `err`=0. Repeat at count 4 → count stays 4 and `err`=0.
- Overflow and bad alloc: a credit to VC0 at count 4 → `err`=1 and the count holds at 4. Alloc of a busy VC → busy stays 1 and `err`=1.
- Async reset mid-packet: assert `rst` low between clock edges with VC2 busy and count 1 → outputs return to reset values before the next edge.
